// File: rtl/layer_3_window_reader.sv
// layer_3_window_reader
//   Walks every KxK convolution window of the IMG_W x IMG_H layer-3 feature
//   map in raster order and issues one buffer read address per kernel tap
//   (kx fastest, then ky; windows ox fastest, then oy). A tap is offered only
//   once the writer's live pixel count shows that pixel has been written.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   conv_start  one-cycle frame start request (honoured only in IDLE)
//   wr_count    pixels written so far this frame (monotonic within a frame)
//   rd_ready    downstream accepts the current tap
//   rd_valid    rd_addr names an already-written pixel and is offered
//   rd_addr     (oy+ky)*IMG_W + (ox+kx)
//   tap_first   current tap is ky=0,kx=0
//   tap_last    current tap is ky=K-1,kx=K-1
//   win_x/win_y output column/row of the current window
//   busy        high while walking the frame
//   done        one-cycle pulse after the final tap transfers
module layer_3_window_reader #(
  parameter int IMG_W  = 12,
  parameter int IMG_H  = 12,
  parameter int K      = 3,
  parameter int ADDR_W = 10,
  parameter int POS_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              conv_start,
  input  logic [ADDR_W-1:0] wr_count,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              tap_first,
  output logic              tap_last,
  output logic [POS_W-1:0]  win_x,
  output logic [POS_W-1:0]  win_y,
  output logic              busy,
  output logic              done
);

  localparam int OW   = IMG_W - K + 1;
  localparam int OH   = IMG_H - K + 1;
  localparam int KC_W = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state, state_next;
  logic [KC_W-1:0]   kx, ky, kx_next, ky_next;
  logic [POS_W-1:0]  ox, oy, ox_next, oy_next;
  logic [ADDR_W-1:0] tap_addr;
  logic              in_run, xfer;
  logic              kx_max, ky_max, ox_max, oy_max;

  assign in_run = (state == S_RUN);
  assign kx_max = (kx == KC_W'(K - 1));
  assign ky_max = (ky == KC_W'(K - 1));
  assign ox_max = (ox == POS_W'(OW - 1));
  assign oy_max = (oy == POS_W'(OH - 1));

  always_comb begin
    tap_addr = (ADDR_W'(oy) + ADDR_W'(ky)) * ADDR_W'(IMG_W)
             + ADDR_W'(ox) + ADDR_W'(kx);
  end

  // Strict compare: a tap equal to wr_count has not been written yet.
  assign rd_valid  = in_run && (tap_addr < wr_count);
  assign xfer      = rd_valid && rd_ready;

  assign rd_addr   = in_run ? tap_addr : '0;
  assign tap_first = in_run && (kx == '0) && (ky == '0);
  assign tap_last  = in_run && kx_max && ky_max;
  assign win_x     = in_run ? ox : '0;
  assign win_y     = in_run ? oy : '0;
  assign busy      = in_run;
  assign done      = (state == S_DONE);

  always_comb begin
    state_next = state;
    kx_next    = kx;
    ky_next    = ky;
    ox_next    = ox;
    oy_next    = oy;
    case (state)
      S_IDLE: begin
        if (conv_start) begin
          state_next = S_RUN;
          kx_next    = '0;
          ky_next    = '0;
          ox_next    = '0;
          oy_next    = '0;
        end
      end
      S_RUN: begin
        // Nested odometer: each counter wraps into the next slower one.
        if (xfer) begin
          if (!kx_max) begin
            kx_next = kx + KC_W'(1);
          end else begin
            kx_next = '0;
            if (!ky_max) begin
              ky_next = ky + KC_W'(1);
            end else begin
              ky_next = '0;
              if (!ox_max) begin
                ox_next = ox + POS_W'(1);
              end else begin
                ox_next = '0;
                if (!oy_max) begin
                  oy_next = oy + POS_W'(1);
                end else begin
                  oy_next    = '0;
                  state_next = S_DONE;
                end
              end
            end
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      kx    <= '0;
      ky    <= '0;
      ox    <= '0;
      oy    <= '0;
    end else begin
      state <= state_next;
      kx    <= kx_next;
      ky    <= ky_next;
      ox    <= ox_next;
      oy    <= oy_next;
    end
  end

endmodule

// File: tb/tb_layer_3_window_reader.sv
// Self-checking bench for layer_3_window_reader: a tap-sequence reference
// table built from the window geometry drives a transaction-level model
// that is compared against every DUT output each cycle.
module tb_layer_3_window_reader;

  localparam int IMG_W = 12;
  localparam int IMG_H = 12;
  localparam int K     = 3;
  localparam int OW    = IMG_W - K + 1;
  localparam int OH    = IMG_H - K + 1;
  localparam int NTAP  = OW * OH * K * K;

  logic       clk = 1'b0;
  logic       rst, conv_start, rd_ready;
  logic [9:0] wr_count;
  logic       rd_valid, tap_first, tap_last, busy, done;
  logic [9:0] rd_addr;
  logic [3:0] win_x, win_y;

  layer_3_window_reader #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .ADDR_W(10), .POS_W(4)
  ) dut (
    .clk(clk), .rst(rst), .conv_start(conv_start), .wr_count(wr_count),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_addr(rd_addr),
    .tap_first(tap_first), .tap_last(tap_last), .win_x(win_x),
    .win_y(win_y), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference tap sequence, straight from the window walk definition.
  int unsigned t_addr[NTAP];
  int unsigned t_x[NTAP];
  int unsigned t_y[NTAP];

  // Model: 0 idle, 1 run, 2 done
  int          m_mode = 0;
  int unsigned m_idx  = 0;
  int unsigned n_ready_run;
  int unsigned n_done_seen;
  int unsigned first_last_wr;
  int unsigned cap[$];

  function automatic int unsigned cur_addr();
    return (m_idx < NTAP) ? t_addr[m_idx] : 0;
  endfunction

  task automatic compare_outputs();
    bit r;
    r = (m_mode == 1);
    check("busy", busy, r);
    check("done", done, m_mode == 2);
    check("rd_valid", rd_valid, r && (cur_addr() < wr_count));
    check("rd_addr", rd_addr, r ? cur_addr() : 0);
    check("tap_first", tap_first, r && (m_idx % 9 == 0));
    check("tap_last", tap_last, r && (m_idx % 9 == 8));
    check("win_x", win_x, r ? t_x[m_idx] : 0);
    check("win_y", win_y, r ? t_y[m_idx] : 0);
  endtask

  task automatic step();
    bit ev;
    #1;
    if (!rst && rd_valid && rd_ready) begin
      cap.push_back(rd_addr);
      if (tap_last && first_last_wr == 0) first_last_wr = wr_count;
    end
    if (done) n_done_seen++;
    ev = (m_mode == 1) && (cur_addr() < wr_count);
    if (m_mode == 1 && rd_ready) n_ready_run++;
    @(posedge clk);
    if (rst) begin
      m_mode = 0;
      m_idx  = 0;
    end else begin
      case (m_mode)
        0: if (conv_start) begin m_mode = 1; m_idx = 0; end
        1: if (ev && rd_ready) begin
             if (m_idx == NTAP - 1) begin m_mode = 2; m_idx = 0; end
             else m_idx++;
           end
        default: m_mode = 0;
      endcase
    end
    #1;
    compare_outputs();
  endtask

  task automatic start_frame();
    cap.delete();
    n_done_seen   = 0;
    first_last_wr = 0;
    conv_start = 1'b1;
    step();
    conv_start = 1'b0;
    n_ready_run = 0;
  endtask

  task automatic finish_frame(input int unsigned limit);
    int unsigned cnt = 0;
    while (m_mode != 0 && cnt < limit) begin
      step();
      cnt++;
    end
    if (m_mode != 0) check("frame_timeout", 1, 0);
  endtask

  int unsigned first9[9] = '{0, 1, 2, 12, 13, 14, 24, 25, 26};

  initial begin
    for (int oy = 0; oy < OH; oy++)
      for (int ox = 0; ox < OW; ox++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++) begin
            int unsigned i;
            i = ((oy * OW + ox) * K + ky) * K + kx;
            t_addr[i] = (oy + ky) * IMG_W + ox + kx;
            t_x[i] = ox;
            t_y[i] = oy;
          end

    // Reset state
    rst = 1'b1; conv_start = 1'b0; rd_ready = 1'b0; wr_count = '0;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // Full frame, all data available, no backpressure
    wr_count = 10'd144; rd_ready = 1'b1;
    start_frame();
    finish_frame(1000);
    check("full_xfers", cap.size(), NTAP);
    check("full_done_pulses", n_done_seen, 1);
    if (cap.size() == NTAP) begin
      for (int i = 0; i < 9; i++) check("full_first9", cap[i], first9[i]);
      check("full_win10_start", cap[9], 1);
      check("full_last_addr", cap[NTAP-1], 143);
    end

    // Data stall at the written-pixel boundary
    wr_count = 10'd25; rd_ready = 1'b1;
    start_frame();
    repeat (20) step();
    check("stall25_valid", rd_valid, 0);
    check("stall25_addr", rd_addr, 25);
    wr_count = 10'd26;
    repeat (2) step();
    check("stall26_valid", rd_valid, 0);
    check("stall26_addr", rd_addr, 26);
    wr_count = 10'd27;
    step();
    check("stall27_xfer", cap[$], 26);
    wr_count = 10'd144;
    finish_frame(1000);
    check("stall_total", cap.size(), NTAP);

    // Backpressure: fixed 1,0,0,1 then random
    wr_count = 10'd144;
    rd_ready = 1'b1;
    start_frame();
    step();
    rd_ready = 1'b0;
    step();
    check("bp_hold_addr", rd_addr, 1);
    check("bp_hold_valid", rd_valid, 1);
    step();
    check("bp_hold_addr2", rd_addr, 1);
    rd_ready = 1'b1;
    step();
    check("bp_xfer_addr1", cap[$], 1);
    begin
      int unsigned cnt = 0;
      while (m_mode != 0 && cnt < 5000) begin
        rd_ready = ($urandom_range(0, 2) != 0);
        step();
        cnt++;
      end
      if (m_mode != 0) check("bp_timeout", 1, 0);
    end
    check("bp_xfers_eq_ready", cap.size(), n_ready_run);
    check("bp_total", cap.size(), NTAP);
    check("bp_done_pulses", n_done_seen, 1);

    // Streaming overlap: writer count climbs one per cycle
    rd_ready = 1'b1; wr_count = '0;
    start_frame();
    begin
      int unsigned cnt = 0;
      while (m_mode != 0 && cnt < 3000) begin
        if (wr_count < 10'd144) wr_count = wr_count + 10'd1;
        step();
        cnt++;
      end
      if (m_mode != 0) check("stream_timeout", 1, 0);
    end
    check("stream_first_win_wr", first_last_wr >= 27, 1);
    check("stream_total", cap.size(), NTAP);
    check("stream_done_pulses", n_done_seen, 1);

    // conv_start pulsed during RUN and in the DONE cycle
    wr_count = 10'd144; rd_ready = 1'b1;
    start_frame();
    begin
      int unsigned cnt = 0;
      while (m_mode != 0 && cnt < 1200) begin
        conv_start = (m_mode == 2) || ($urandom_range(0, 3) == 0);
        step();
        cnt++;
      end
      conv_start = 1'b0;
      if (m_mode != 0) check("ign_timeout", 1, 0);
    end
    check("ign_total", cap.size(), NTAP);
    if (cap.size() == NTAP)
      for (int i = 0; i < NTAP; i += 97) check("ign_seq", cap[i], t_addr[i]);
    check("ign_done_pulses", n_done_seen, 1);
    repeat (2) step();
    check("ign_idle_after", busy, 0);

    // Asynchronous reset mid-frame
    wr_count = 10'd144; rd_ready = 1'b1;
    start_frame();
    repeat (50) step();
    #2 rst = 1'b1;
    #1;
    m_mode = 0; m_idx = 0;
    check("arst_busy", busy, 0);
    check("arst_valid", rd_valid, 0);
    check("arst_addr", rd_addr, 0);
    check("arst_first", tap_first, 0);
    check("arst_last", tap_last, 0);
    check("arst_win", {win_y, win_x}, 0);
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();
    check("arst_post_valid", rd_valid, 0);
    start_frame();
    check("arst_restart_addr", rd_addr, 0);
    check("arst_restart_valid", rd_valid, 1);
    finish_frame(1000);
    check("arst_restart_total", cap.size(), NTAP);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
